// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: one outstanding ld/std, fixed busy latency,
// doubleword-indexed array with an out-of-range error response.
module data_mem_responder #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              resp_write,
  output logic [1:0]        dbg_state
);

  // Handshakes: a request transfers on an edge where req_valid && req_ready;
  // a response transfers on an edge where resp_valid && resp_ready. Once
  // raised, resp_valid and the response fields hold until that transfer.

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                in_range;
  logic                commit;
  logic                mem_we;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Full-width compare so that high address bits can never alias into the array.
  assign in_range = (addr_q < ADDR_W'(DEPTH));
  assign idx      = addr_q[IDX_W-1:0];
  assign commit   = (state_q == S_BUSY) && (cnt_q == 4'd0);
  assign mem_we   = commit && write_q && in_range && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          if (!in_range) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (write_q) begin
            rdata_d = '0;
            err_d   = 1'b0;
          end else begin
            rdata_d = mem_q[idx];
            err_d   = 1'b0;
          end
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign resp_write = write_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the uPOWER load/store path. It accepts load (`ld`) and store (`std`) requests from the datapath over a valid/ready handshake and holds them for a fixed access latency. It commits stores into, or reads loads from, a doubleword-indexed storage array, then returns one response per request. It replaces the zero-wait data memory so that the load/store datapath and the control unit can be exercised against a multi-cycle memory.

## Interface
Parameters:
- `DATA_W`, 64: doubleword width; matches the 64-bit register file and ALU.
- `ADDR_W`, 64: request address width; the ALU result is passed through unmodified.
- `DEPTH`, 256: number of doublewords in the array; must be a power of two, ≥ 2.
- `LATENCY`, 2: number of busy cycles between accept and response; legal range 1–15.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset; sampled on the rising edge of `clk`.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: responder can accept a request.
- `req_write`, input, 1: 1 = store (`std`), 0 = load (`ld`).
- `req_addr`, input, `ADDR_W`: doubleword index (ALU result of base plus DS-form displacement).
- `req_wdata`, input, `DATA_W`: store data (the second register-read port value).
- `resp_valid`, output, 1: response present.
- `resp_ready`, input, 1: datapath accepts the response.
- `resp_rdata`, output, `DATA_W`: load data; 0 for stores and for errors.
- `resp_err`, output, 1: address out of range (`req_addr >= DEPTH`).
- `resp_write`, output, 1: echo of `req_write` for the outstanding transaction.

## Operation
- FSM with three states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: capture `req_write`, `req_addr` and `req_wdata`; load `cnt`=LATENCY-1; go to BUSY.
- BUSY:
  - `req_ready`=0.
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`==0 on a clock edge, perform the access on that edge and go to RESP.
    - Load: `resp_rdata` ← `mem[addr]`.
    - Store: `mem[addr]` ← wdata; `resp_rdata` ← 0.
    - Out of range (`addr` ≥ DEPTH, with all `ADDR_W` bits compared): no array write; `resp_rdata`=0; `resp_err`=1.
- RESP:
  - `resp_valid`=1.
  - `resp_rdata`, `resp_err` and `resp_write` are held stable until `resp_ready`.
  - On `resp_ready`: go to IDLE.
- Array indexing uses `addr[log2(DEPTH)-1:0]` only after the range check passes; addresses never wrap.
- The array is not cleared by reset; contents persist across `rst`. Reading a never-written location returns X in simulation; benches write before reading.
- Only one transaction is outstanding at a time. `req_valid` while not in IDLE is ignored; the requester must hold it until `req_ready`.

## Timing
- Reset values: `req_ready`=0 while `rst` is high, and 1 on the first cycle after reset deasserts. `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `resp_write`=0, state=IDLE, `cnt`=0.
- Accept edge E0 (`req_valid` and `req_ready` both high).
- BUSY occupies cycles E0..E0+LATENCY.
- The access commits on edge E0+LATENCY.
- `resp_valid` is high from edge E0+LATENCY until the edge where `resp_ready` is sampled high.
- `req_ready` returns high on the cycle after the response handshake.
- Minimum occupancy is LATENCY+2 cycles per transaction when `resp_ready` is held high.
- A store is visible to a load accepted after its response handshake. There is no forwarding; none is needed with one transaction outstanding.
- Reset mid-operation: `rst` in BUSY before the commit edge aborts the transaction. The store is not written and no response is issued. `rst` on the commit edge itself also suppresses the write, because reset has priority.
- `rst` in RESP drops `resp_valid` on the same edge; the committed store stays in the array.
- `resp_ready` high while `resp_valid`=0 has no effect.

## Test plan
- Store then load, LATENCY=2:
  - `std` addr=2, wdata=8 is accepted at E0; `resp_valid` rises after E0+2 with `resp_err`=0 and `resp_write`=1.
  - A following `ld` addr=2 returns `resp_rdata`=8 exactly 2 edges after its accept.
- Back-to-back traffic with `resp_ready` tied high: fill addresses 1..10 with value 8, then read all ten back.
  - Every read returns 8.
  - Exactly one response per request, spaced LATENCY+2 cycles apart.
- Response stall: hold `resp_ready`=0 for 5 cycles after a load of 0x5.
  - `resp_valid` and `resp_rdata`=0x5 stay stable throughout.
  - `req_ready` stays 0 throughout, and a new `req_valid` is ignored.
- Out of range: `std` addr=DEPTH (256), wdata=0xFFFF.
  - Response has `resp_err`=1 and `resp_rdata`=0.
  - A subsequent `ld` addr=0 returns its prior value (no wrap-around write).
- Reset mid-operation:
  - Store 0xAA to addr=3, then issue `std` addr=3, wdata=0x55 and pulse `rst` during BUSY.
  - No response is issued.
  - After reset, `ld` addr=3 returns 0xAA; all outputs were at their reset values on the cycle after `rst`.
- LATENCY=1 build: a load response appears 1 edge after accept; LATENCY=15 build: it appears 15 edges after accept.
